// File: rtl/wordline_encoder_16_4_pkg.sv
// Shared sizing and state encoding for the 16-to-4 wordline encoder.
package wordline_encoder_16_4_pkg;

  localparam int N_REGS = 16;
  localparam int ID_W   = $clog2(N_REGS);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_DRAIN = 1'b1
  } state_t;

endpackage

// File: rtl/wordline_encoder_16_4_ffs.sv
// Combinational find-first-set over 16 requests, searching upward from start and
// wrapping 15->0; idx is 0 when no request is set.
module wordline_encoder_16_4_ffs
  import wordline_encoder_16_4_pkg::*;
(
  input  logic [N_REGS-1:0] req,
  input  logic [ID_W-1:0]   start,
  output logic [ID_W-1:0]   idx,
  output logic              any
);

  logic [ID_W-1:0] pos;

  // Scan from the farthest offset down so the nearest set bit is the last write.
  always_comb begin
    idx = '0;
    any = 1'b0;
    pos = '0;
    for (int i = N_REGS - 1; i >= 0; i--) begin
      pos = start + ID_W'(i);
      if (req[pos]) begin
        idx = pos;
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wordline_encoder_16_4.sv
// Serialises a 16-bit request mask into 4-bit register IDs, one per handshake.
// Define ENC_ROUND_ROBIN_EN for rotating selection; otherwise the lowest index wins.
//
// state    | meaning
// ST_IDLE  | waiting for a non-zero mask; mask_ready high
// ST_DRAIN | offering the selected pending ID; id_valid high
module wordline_encoder_16_4
  import wordline_encoder_16_4_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_REGS-1:0] mask_in,
  input  logic              mask_valid,
  output logic              mask_ready,
  output logic [ID_W-1:0]   reg_id,
  output logic              id_valid,
  input  logic              id_ready,
  output logic              id_last,
  output logic [N_REGS-1:0] pending
);

  state_t            state_q, state_d;
  logic [N_REGS-1:0] pending_q, pending_d;
  logic [ID_W-1:0]   sel_idx;
  logic [ID_W-1:0]   start;
  logic              sel_any;
  logic              single_bit;
  logic              accept_id;

`ifdef ENC_ROUND_ROBIN_EN
  logic [ID_W-1:0] rr_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (accept_id) begin
      rr_ptr <= reg_id + ID_W'(1);
    end
  end

  assign start = rr_ptr;
`else
  assign start = '0;
`endif

  wordline_encoder_16_4_ffs u_ffs (
    .req   (pending_q),
    .start (start),
    .idx   (sel_idx),
    .any   (sel_any)
  );

  // Exactly one bit left: non-zero and clearing the lowest set bit leaves nothing.
  assign single_bit = (pending_q != '0) &&
                      ((pending_q & (pending_q - N_REGS'(1))) == '0);

  assign mask_ready = (state_q == ST_IDLE);
  assign id_valid   = (state_q == ST_DRAIN) && sel_any;
  assign reg_id     = id_valid ? sel_idx : '0;
  assign id_last    = id_valid && single_bit;
  assign accept_id  = id_valid && id_ready;
  assign pending    = pending_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    unique case (state_q)
      ST_IDLE: begin
        if (mask_valid && (mask_in != '0)) begin
          pending_d = mask_in;
          state_d   = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (accept_id) begin
          pending_d = pending_q & ~(N_REGS'(1) << reg_id);
          if (id_last) begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d   = ST_IDLE;
        pending_d = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_wordline_encoder_16_4.sv
// Self-checking bench for wordline_encoder_16_4: table vectors, hand-written corner
// sequences and randomized masks against a set-walking reference model.
module tb_wordline_encoder_16_4;

  logic        clk;
  logic        rst_n;
  logic [15:0] mask_in;
  logic        mask_valid;
  logic        mask_ready;
  logic [3:0]  reg_id;
  logic        id_valid;
  logic        id_ready;
  logic        id_last;
  logic [15:0] pending;

  int total;
  int bad;
  int m_rr;
  int drain_cycles;
  int got_ids[$];

  wordline_encoder_16_4 dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mask_in    (mask_in),
    .mask_valid (mask_valid),
    .mask_ready (mask_ready),
    .reg_id     (reg_id),
    .id_valid   (id_valid),
    .id_ready   (id_ready),
    .id_last    (id_last),
    .pending    (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [15:0] mask;
    int          exp_cnt;
    int          exp_first;
    int          exp_last;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference selection: first remaining register at or after rr, wrapping modulo 16.
  function automatic int pick(input logic [15:0] rem, input int rr);
    for (int off = 0; off < 16; off++) begin
      if (rem[(rr + off) % 16]) return (rr + off) % 16;
    end
    return -1;
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    rst_n      = 1'b0;
    mask_valid = 1'b0;
    mask_in    = '0;
    id_ready   = 1'b0;
    m_rr       = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Offers one mask, then walks the drain cycle by cycle against the model.
  task automatic run_mask(input logic [15:0] m, input int ready_pct, input bit jam);
    logic [15:0] rem;
    int          e;
    got_ids.delete();
    drain_cycles = 0;
    @(negedge clk);
    check("accept_ready", 32'(mask_ready), 32'd1);
    mask_in    = m;
    mask_valid = 1'b1;
    id_ready   = 1'b0;
    rem        = m;
    @(negedge clk);
    mask_valid = 1'b0;
    while (1) begin
      if (rem == 16'h0) begin
        check("idle_ready", 32'(mask_ready), 32'd1);
        check("idle_valid", 32'(id_valid), 32'd0);
        check("idle_pending", 32'(pending), 32'd0);
        break;
      end
      e = pick(rem, m_rr);
      check("drain_valid", 32'(id_valid), 32'd1);
      check("drain_ready_low", 32'(mask_ready), 32'd0);
      check("drain_id", 32'(reg_id), 32'(e));
      check("drain_last", 32'(id_last), 32'($countones(rem) == 1));
      check("drain_pending", 32'(pending), 32'(rem));
      id_ready = ($urandom_range(99) < ready_pct);
      if (jam) begin
        mask_valid = 1'($urandom_range(1));
        mask_in    = 16'($urandom);
      end
      if (id_ready) begin
        got_ids.push_back(e);
        rem[e] = 1'b0;
`ifdef ENC_ROUND_ROBIN_EN
        m_rr = (e + 1) % 16;
`endif
      end
      drain_cycles++;
      if (drain_cycles > 400) begin
        total++;
        bad++;
        $display("FAIL drain_timeout: got=%0d cycles want<=400", drain_cycles);
        break;
      end
      @(negedge clk);
    end
    id_ready   = 1'b0;
    mask_valid = 1'b0;
  endtask

  vec_t vecs[8];
  logic [15:0] rmask;
  int          want;

  initial begin
    total = 0;
    bad   = 0;
    m_rr  = 0;
    rst_n = 1'b1;
    mask_in = '0;
    mask_valid = 1'b0;
    id_ready = 1'b0;

    // Expectations hold in both selection modes because each vector starts from reset.
    vecs[0] = '{16'h8421, 4, 0, 15};
    vecs[1] = '{16'h0000, 0, 0, 0};
    vecs[2] = '{16'h0003, 2, 0, 1};
    vecs[3] = '{16'hFFFF, 16, 0, 15};
    vecs[4] = '{16'h8000, 1, 15, 15};
    vecs[5] = '{16'h0001, 1, 0, 0};
    vecs[6] = '{16'hA5A5, 8, 0, 15};
    vecs[7] = '{16'h0F00, 4, 8, 11};

    // Reset state, during and after reset.
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_mask_ready", 32'(mask_ready), 32'd1);
    check("rst_id_valid", 32'(id_valid), 32'd0);
    check("rst_pending", 32'(pending), 32'd0);
    check("rst_reg_id", 32'(reg_id), 32'd0);
    check("rst_id_last", 32'(id_last), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", 32'(mask_ready), 32'd1);
    check("post_rst_valid", 32'(id_valid), 32'd0);

    // Table vectors at full throughput.
    for (int v = 0; v < 8; v++) begin
      apply_reset();
      run_mask(vecs[v].mask, 100, 1'b0);
      check("vec_count", 32'(got_ids.size()), 32'(vecs[v].exp_cnt));
      check("vec_cycles", 32'(drain_cycles), 32'(vecs[v].exp_cnt));
      if (vecs[v].exp_cnt > 0 && got_ids.size() > 0) begin
        check("vec_first", 32'(got_ids[0]), 32'(vecs[v].exp_first));
        check("vec_last", 32'(got_ids[got_ids.size()-1]), 32'(vecs[v].exp_last));
        for (int j = 1; j < got_ids.size(); j++) begin
          check("vec_ascending", 32'(got_ids[j] > got_ids[j-1]), 32'd1);
        end
      end
    end

    // Explicit order for 16'h8421.
    apply_reset();
    run_mask(16'h8421, 100, 1'b0);
    if (got_ids.size() == 4) begin
      check("seq8421_0", 32'(got_ids[0]), 32'd0);
      check("seq8421_1", 32'(got_ids[1]), 32'd5);
      check("seq8421_2", 32'(got_ids[2]), 32'd10);
      check("seq8421_3", 32'(got_ids[3]), 32'd15);
    end else begin
      check("seq8421_len", 32'(got_ids.size()), 32'd4);
    end

    // Consumer stalls for three cycles: first ID held stable.
    apply_reset();
    @(negedge clk);
    mask_in = 16'h0003;
    mask_valid = 1'b1;
    @(negedge clk);
    mask_valid = 1'b0;
    repeat (3) begin
      check("stall_id", 32'(reg_id), 32'd0);
      check("stall_valid", 32'(id_valid), 32'd1);
      check("stall_last", 32'(id_last), 32'd0);
      @(negedge clk);
    end
    id_ready = 1'b1;
    check("stall_rel_id0", 32'(reg_id), 32'd0);
    @(negedge clk);
    check("stall_rel_id1", 32'(reg_id), 32'd1);
    check("stall_rel_last", 32'(id_last), 32'd1);
    @(negedge clk);
    id_ready = 1'b0;
    check("stall_done_ready", 32'(mask_ready), 32'd1);
    check("stall_done_valid", 32'(id_valid), 32'd0);

    // Reset asserted after the first ID of a full mask.
    apply_reset();
    @(negedge clk);
    mask_in = 16'hFFFF;
    mask_valid = 1'b1;
    @(negedge clk);
    mask_valid = 1'b0;
    id_ready = 1'b1;
    check("midrst_first", 32'(reg_id), 32'd0);
    @(negedge clk);
    check("midrst_second", 32'(reg_id), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_valid", 32'(id_valid), 32'd0);
    check("midrst_pending", 32'(pending), 32'd0);
    check("midrst_ready", 32'(mask_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    m_rr = 0;
    repeat (4) begin
      @(negedge clk);
      check("midrst_no_stale", 32'(id_valid), 32'd0);
      check("midrst_pend_zero", 32'(pending), 32'd0);
    end
    id_ready = 1'b0;

    // Selection across consecutive masks.
    apply_reset();
    run_mask(16'h0010, 100, 1'b0);
    check("xmask_first_cnt", 32'(got_ids.size()), 32'd1);
    run_mask(16'h0021, 100, 1'b0);
`ifdef ENC_ROUND_ROBIN_EN
    want = 5;
`else
    want = 0;
`endif
    check("xmask_cnt", 32'(got_ids.size()), 32'd2);
    if (got_ids.size() == 2) begin
      check("xmask_id0", 32'(got_ids[0]), 32'(want));
      check("xmask_id1", 32'(got_ids[1]), 32'(5 - want));
    end

    // Randomized masks, random back-pressure, junk on mask_valid while draining.
    apply_reset();
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(3))
        0: rmask = 16'($urandom);
        1: rmask = 16'h1 << $urandom_range(15);
        2: rmask = 16'($urandom) & 16'($urandom);
        default: rmask = ($urandom_range(3) == 0) ? 16'h0 : ~(16'h1 << $urandom_range(15));
      endcase
      run_mask(rmask, 60, 1'b1);
      check("rand_count", 32'(got_ids.size()), 32'($countones(rmask)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
